// File: rtl/lcs_frame_requester_if.sv
// lcs_frame_requester_if: LCS req/ack byte-read link between frame requester and responder
// Signals: req (read request), addrLCS (9-bit byte address), ack (responder acknowledge,
// asynchronous to the requester clock), dataTx (8-bit responder data)
// Modports: master = requester side, slave = responder side
interface lcs_frame_requester_if;
    logic       req;
    logic       ack;
    logic [8:0] addrLCS;
    logic [7:0] dataTx;
    modport master (output req, addrLCS, input ack, dataTx);
    modport slave  (input req, addrLCS, output ack, dataTx);
endinterface

// File: rtl/lcs_frame_requester.sv
// lcs_frame_requester: sweeps addrLCS 0..FRAME_LEN-1 over the LCS req/ack link and writes each byte to a frame buffer
// Optional feature macro: LCS_REQ_TIMEOUT_EN (ack timeout writes FILL, sets sticky timeout_err, sweep continues)
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse, begins a frame when idle
//   lcs (master)      req/addrLCS out, ack/dataTx in
//   wr_en/addr/data   one-cycle buffer write of the sampled byte
//   busy              high from accepted start until DONE exits
//   done              one-cycle pulse after the last write
//   timeout_err       sticky ack-timeout flag (0 without the macro)
module lcs_frame_requester #(
    parameter int         FRAME_LEN = 192,
    parameter int         SETTLE    = 4,
`ifdef LCS_REQ_TIMEOUT_EN
    parameter int         GAP       = 64,
    parameter int         TIMEOUT   = 1023,
    parameter logic [7:0] FILL      = 8'hFF
`else
    parameter int         GAP       = 64
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    lcs_frame_requester_if.master        lcs,
    output logic                         wr_en,
    output logic [8:0]                   wr_addr,
    output logic [7:0]                   wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int GW = $clog2(GAP + 1);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACKWAIT, S_SETTLE, S_SAMPLE, S_GAP, S_DONE} state_t;
    state_t        state, nxt;
    logic [1:0]    ackSync;
    logic          ackPrev, ackRise, ackTimeout;
    logic          reqR;
    logic [8:0]    addrR;
    logic [SW-1:0] settleCnt;
    logic [GW-1:0] gapCnt;
    logic          settleDone, gapDone, lastAddr;
    logic [7:0]    sampleData;
    assign lcs.req     = reqR;
    assign lcs.addrLCS = addrR;
    // ack is only accepted as a fresh rise of the synchronized level
    assign ackRise    = ackSync[1] & ~ackPrev;
    assign settleDone = settleCnt == SW'(SETTLE - 1);
    assign gapDone    = gapCnt == GW'(GAP - 1);
    assign lastAddr   = addrR == 9'(FRAME_LEN - 1);
`ifdef LCS_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] toCnt;
    logic          toFlag, timeoutErr;
    assign ackTimeout  = toCnt == TW'(TIMEOUT - 1);
    assign sampleData  = toFlag ? FILL : lcs.dataTx;
    assign timeout_err = timeoutErr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toCnt      <= '0;
            toFlag     <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            if (state == S_IDLE && start) timeoutErr <= 1'b0;
            if (state == S_REQ) begin
                toCnt  <= '0;
                toFlag <= 1'b0;
            end
            if (state == S_ACKWAIT && !ackRise) begin
                toCnt <= toCnt + 1'b1;
                if (ackTimeout) begin
                    toFlag     <= 1'b1;
                    timeoutErr <= 1'b1;
                end
            end
        end
    end
`else
    assign ackTimeout  = 1'b0;
    assign sampleData  = lcs.dataTx;
    assign timeout_err = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = start ? S_REQ : S_IDLE;
            S_REQ:     nxt = S_ACKWAIT;
            S_ACKWAIT: nxt = ackRise ? S_SETTLE : ackTimeout ? S_SAMPLE : S_ACKWAIT;
            S_SETTLE:  nxt = settleDone ? S_SAMPLE : S_SETTLE;
            S_SAMPLE:  nxt = S_GAP;
            S_GAP:     nxt = gapDone ? (lastAddr ? S_DONE : S_REQ) : S_GAP;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end
    always_comb begin
        busy = state != S_IDLE;
        done = state == S_DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ackSync   <= '0;
            ackPrev   <= 1'b0;
            reqR      <= 1'b0;
            addrR     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            settleCnt <= '0;
            gapCnt    <= '0;
        end else begin
            ackSync <= {ackSync[0], lcs.ack};
            ackPrev <= ackSync[1];
            wr_en   <= state == S_SAMPLE;
            case (state)
                S_IDLE: if (start) addrR <= '0;
                S_REQ: begin
                    reqR      <= 1'b1;
                    settleCnt <= '0;
                    gapCnt    <= '0;
                end
                S_SETTLE: settleCnt <= settleCnt + 1'b1;
                S_SAMPLE: begin
                    reqR    <= 1'b0;
                    wr_addr <= addrR;
                    wr_data <= sampleData;
                end
                S_GAP: begin
                    gapCnt <= gapCnt + 1'b1;
                    if (gapDone && !lastAddr) addrR <= addrR + 9'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcs_frame_requester.sv
// tb_lcs_frame_requester: directed bench with a model responder returning addr^8'h5A
module tb_lcs_frame_requester;
    localparam int FL = 8;
    localparam int ST = 4;
    localparam int GP = 8;
    localparam int TO = 31;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       wr_en, busy, done, timeout_err;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] expData [8];
    int checks = 0;
    int errors = 0;
    int silentAddr = -1;
    int wrIdx = 0;
    int doneCnt = 0;
    int cyc = 0;
    int reqCyc = 0;
    int lowCnt = 0;
    int d0 = 0;
    bit lowActive = 0;
    bit prevReq = 0;
    bit prevBusy = 0;

    lcs_frame_requester_if lcs();

`ifdef LCS_REQ_TIMEOUT_EN
    lcs_frame_requester #(.FRAME_LEN(FL), .SETTLE(ST), .GAP(GP), .TIMEOUT(TO), .FILL(8'hFF)) dut (
`else
    lcs_frame_requester #(.FRAME_LEN(FL), .SETTLE(ST), .GAP(GP)) dut (
`endif
        .clk(clk), .rst(rst), .start(start), .lcs(lcs),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    // Responder: 8-cycle ack pulse, then a short glitch pulse that lands in GAP
    initial begin
        lcs.ack = 1'b0;
        lcs.dataTx = 8'h00;
        forever begin
            @(posedge lcs.req);
            if (int'(lcs.addrLCS) != silentAddr) begin
                repeat (3) @(negedge clk);
                lcs.dataTx = lcs.addrLCS[7:0] ^ 8'h5A;
                lcs.ack = 1'b1;
                repeat (8) @(negedge clk);
                lcs.ack = 1'b0;
                repeat (2) @(negedge clk);
                lcs.ack = 1'b1;
                repeat (3) @(negedge clk);
                lcs.ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (busy && !prevBusy) wrIdx = 0;
        if (wr_en) begin
            chk("wr_addr", int'(wr_addr), wrIdx);
            chk("wr_data", int'(wr_data), int'(expData[wrIdx % 8]));
            if (int'(wr_addr) == silentAddr) chk("timeout_lat", cyc - reqCyc, TO + 1);
            wrIdx++;
        end
        if (done) doneCnt++;
        if (lcs.req && !prevReq) begin
            reqCyc = cyc;
            if (lowActive) chk("req_gap", lowCnt, GP + 1);
        end
        if (!lcs.req && prevReq) begin
            lowActive = busy;
            lowCnt = 0;
        end
        if (!lcs.req && lowActive) lowCnt++;
        if (!busy) lowActive = 0;
        prevReq = lcs.req;
        prevBusy = busy;
    end

    initial begin
        int n;
        expData = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C, 8'h5D};
        repeat (3) @(negedge clk);
        chk("rst_req", int'(lcs.req), 0);
        chk("rst_addr", int'(lcs.addrLCS), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr", int'(wr_en) + int'(wr_addr) + int'(wr_data), 0);
        chk("rst_terr", int'(timeout_err), 0);
        rst = 1'b0;
        @(negedge clk);
        d0 = doneCnt;
        pulseStart();
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        repeat (30) @(negedge clk);
        pulseStart();
        waitDone(1000);
        pulseStart();
        repeat (40) @(negedge clk);
        chk("frame_writes", wrIdx, FL);
        chk("frame_done", doneCnt - d0, 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_req", int'(lcs.req), 0);
        chk("addr_hold", int'(lcs.addrLCS), FL - 1);
        chk("terr_clean", int'(timeout_err), 0);

        d0 = doneCnt;
        pulseStart();
        n = 0;
        while (!(lcs.addrLCS == 9'd5 && lcs.ack) && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_addr5", int'(lcs.addrLCS), 5);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_req", int'(lcs.req), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_wr_en", int'(wr_en), 0);
        chk("arst_addr", int'(lcs.addrLCS), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("partial_writes", wrIdx, 5);
        chk("no_partial_done", doneCnt - d0, 0);
        d0 = doneCnt;
        pulseStart();
        waitDone(1000);
        repeat (5) @(negedge clk);
        chk("restart_writes", wrIdx, FL);
        chk("restart_done", doneCnt - d0, 1);

`ifdef LCS_REQ_TIMEOUT_EN
        silentAddr = 3;
        expData[3] = 8'hFF;
        d0 = doneCnt;
        pulseStart();
        waitDone(2000);
        @(negedge clk);
        chk("to_writes", wrIdx, FL);
        chk("to_done", doneCnt - d0, 1);
        chk("to_err_set", int'(timeout_err), 1);
        silentAddr = -1;
        expData[3] = 8'h59;
        pulseStart();
        chk("to_err_cleared", int'(timeout_err), 0);
        waitDone(1000);
        repeat (5) @(negedge clk);
        chk("post_to_writes", wrIdx, FL);
`else
        silentAddr = 3;
        pulseStart();
        repeat (300) @(negedge clk);
        chk("stall_req", int'(lcs.req), 1);
        chk("stall_addr", int'(lcs.addrLCS), 3);
        chk("stall_busy", int'(busy), 1);
        chk("stall_writes", wrIdx, 3);
        chk("stall_terr", int'(timeout_err), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
